// File: rtl/push_cond_pkg.sv
// Shared constants for the push-button conditioner: channel FSM encoding,
// button indices and a counter-width helper.
package push_cond_pkg;

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam int PB_U   = 0;
  localparam int PB_D   = 1;
  localparam int PB_L   = 2;
  localparam int PB_R   = 3;
  localparam int PB_M   = 4;
  localparam int NUM_PB = 5;

  // Counter width for a count range 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/push_button_channel.sv
// One button: 2-flop synchroniser, debounce FSM and optional hold-to-repeat,
// advancing only on the shared debounce tick.
module push_button_channel
  import push_cond_pkg::*;
#(
  parameter int DEBOUNCE_TICKS      = 10,
  parameter int REPEAT_DELAY_TICKS  = 500,
  parameter int REPEAT_PERIOD_TICKS = 100,
  parameter bit REPEAT_EN           = 1'b0
) (
  input  logic clk_osc,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic pulse,
  output logic rel
);

  localparam int DW = cnt_w(DEBOUNCE_TICKS);
  localparam int RW = cnt_w(REPEAT_DELAY_TICKS);
  localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] RCNT_LAST   = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] RCNT_RELOAD = RW'(REPEAT_DELAY_TICKS - REPEAT_PERIOD_TICKS);

  logic          sync_p0;
  logic          sync_p1;
  logic          s;
  logic [1:0]    state;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;

  assign s = sync_p1;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // A change of s is handled before the tick, so a coincident tick is dropped.
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      state <= RELEASED;
      dcnt  <= '0;
      rcnt  <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
      rel   <= 1'b0;
    end else begin
      pulse <= 1'b0;
      rel   <= 1'b0;
      case (state)
        RELEASED: begin
          if (s) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
          end else if (tick) begin
            if (dcnt == DCNT_LAST) begin
              state <= HELD;
              level <= 1'b1;
              pulse <= 1'b1;
              rcnt  <= '0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else if (tick && REPEAT_EN) begin
            // Reload keeps later repeats one period apart without a wider counter.
            if (rcnt == RCNT_LAST) begin
              pulse <= 1'b1;
              rcnt  <= RCNT_RELOAD;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= HELD;
            rcnt  <= '0;
          end else if (tick) begin
            if (dcnt == DCNT_LAST) begin
              state <= RELEASED;
              level <= 1'b0;
              rel   <= 1'b1;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/push_button_conditioner.sv
// Conditions the five board push buttons: shared debounce tick generator
// feeding one independent channel per button.
module push_button_conditioner
  import push_cond_pkg::*;
#(
  parameter int               TICK_DIV            = 100000,
  parameter int               DEBOUNCE_TICKS      = 10,
  parameter int               REPEAT_DELAY_TICKS  = 500,
  parameter int               REPEAT_PERIOD_TICKS = 100,
  parameter logic [NUM_PB-1:0] REPEAT_MASK        = 5'b00011
) (
  input  logic              clk_osc,
  input  logic              reset,
  input  logic [NUM_PB-1:0] push_raw,
  output logic [NUM_PB-1:0] push_level,
  output logic [NUM_PB-1:0] push_pulse,
  output logic [NUM_PB-1:0] push_release
);

  localparam int TW = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
    push_button_channel #(
      .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS),
      .REPEAT_EN           (REPEAT_MASK[i])
    ) u_ch (
      .clk_osc (clk_osc),
      .reset   (reset),
      .raw     (push_raw[i]),
      .tick    (tick),
      .level   (push_level[i]),
      .pulse   (push_pulse[i]),
      .rel     (push_release[i])
    );
  end

endmodule

// File: tb/tb_push_button_conditioner.sv
// Bench for push_button_conditioner: directed scenarios plus random button
// activity, all outputs compared every cycle against a behavioural model.
module tb_push_button_conditioner;
  import push_cond_pkg::*;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam logic [4:0] MASK = 5'b00011;

  logic       clk_osc = 1'b0;
  logic       reset;
  logic [4:0] push_raw;
  logic [4:0] push_level;
  logic [4:0] push_pulse;
  logic [4:0] push_release;

  push_button_conditioner #(
    .TICK_DIV            (TD),
    .DEBOUNCE_TICKS      (DB),
    .REPEAT_DELAY_TICKS  (RD),
    .REPEAT_PERIOD_TICKS (RP)
  ) dut (
    .clk_osc      (clk_osc),
    .reset        (reset),
    .push_raw     (push_raw),
    .push_level   (push_level),
    .push_pulse   (push_pulse),
    .push_release (push_release)
  );

  always #5 clk_osc = ~clk_osc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a press/release is accepted once the synchronised input
  // has been stable for DB whole ticks; repeats fire at RD, RD+RP, ... ticks
  // of uninterrupted hold.
  logic [4:0] e_level = '0;
  logic [4:0] e_pulse = '0;
  logic [4:0] e_rel   = '0;
  logic [4:0] m_sa = '0, m_sb = '0, m_prev = '0;
  int stab[5];
  int hold[5];
  int m_cyc = 0;

  initial begin
    forever begin
      @(posedge clk_osc or posedge reset);
      if (reset) begin
        e_level = '0; e_pulse = '0; e_rel = '0;
        m_sa = '0; m_sb = '0; m_prev = '0; m_cyc = 0;
        for (int i = 0; i < 5; i++) begin stab[i] = 0; hold[i] = 0; end
      end else begin
        bit t;
        t = ((m_cyc % TD) == TD - 1);
        m_cyc++;
        e_pulse = '0;
        e_rel   = '0;
        for (int i = 0; i < 5; i++) begin
          logic sv;
          sv = m_sb[i];
          if (sv != m_prev[i]) begin
            stab[i] = 0;
            if (sv && e_level[i]) hold[i] = 0;
          end else if (t) begin
            stab[i]++;
            hold[i]++;
            if (sv && !e_level[i] && stab[i] == DB) begin
              e_level[i] = 1'b1; e_pulse[i] = 1'b1; hold[i] = 0;
            end else if (!sv && e_level[i] && stab[i] == DB) begin
              e_level[i] = 1'b0; e_rel[i] = 1'b1;
            end else if (sv && e_level[i] && MASK[i] && hold[i] >= RD && ((hold[i] - RD) % RP) == 0) begin
              e_pulse[i] = 1'b1;
            end
          end
          m_prev[i] = sv;
        end
        m_sb = m_sa;
        m_sa = push_raw;
      end
    end
  end

  int cyc = 0;
  initial forever begin @(posedge clk_osc); cyc++; end

  int  pcnt[5];
  int  rcnt_obs[5];
  int  fp[5];
  int  fr[5];
  int  pt1[$];
  bit  saw_all;

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) begin pcnt[i] = 0; rcnt_obs[i] = 0; fp[i] = -1; fr[i] = -1; end
    pt1.delete();
    saw_all = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk_osc);
      chk("model_level", 32'(push_level), 32'(e_level));
      chk("model_pulse", 32'(push_pulse), 32'(e_pulse));
      chk("model_release", 32'(push_release), 32'(e_rel));
      for (int i = 0; i < 5; i++) begin
        if (push_pulse[i]) begin
          pcnt[i]++;
          if (fp[i] < 0) fp[i] = cyc;
          if (i == PB_D) pt1.push_back(cyc);
        end
        if (push_release[i]) begin
          rcnt_obs[i]++;
          if (fr[i] < 0) fr[i] = cyc;
        end
      end
      if (push_pulse == 5'b11111) saw_all = 1'b1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_osc);
    #1;
  endtask

  int c0;
  int dur[5];

  initial begin
    push_raw = '0;
    reset    = 1'b1;
    clear_counts();
    wait_cyc(3);
    chk("rst_level", 32'(push_level), 0);
    chk("rst_pulse", 32'(push_pulse), 0);
    chk("rst_release", 32'(push_release), 0);
    reset = 1'b0;
    wait_cyc(5);

    // Clean press on the masked middle button
    clear_counts();
    push_raw[PB_M] = 1'b1; c0 = cyc;
    wait_cyc(40);
    chk("clean_npulse", pcnt[PB_M], 1);
    chk("clean_latency_in_11_15", 32'((fp[PB_M] - c0 >= 11) && (fp[PB_M] - c0 <= 15)), 1);
    chk("clean_level", 32'(push_level[PB_M]), 1);
    push_raw[PB_M] = 1'b0;
    wait_cyc(20);
    chk("clean_nrelease", rcnt_obs[PB_M], 1);
    chk("clean_level_after", 32'(push_level[PB_M]), 0);

    // Bouncing input never settles long enough
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      push_raw[PB_U] = ~push_raw[PB_U];
      wait_cyc(3);
    end
    push_raw[PB_U] = 1'b0;
    wait_cyc(20);
    chk("bounce_npulse", pcnt[PB_U], 0);
    chk("bounce_nrelease", rcnt_obs[PB_U], 0);
    chk("bounce_level", 32'(push_level[PB_U]), 0);

    // Auto-repeat on down button
    clear_counts();
    push_raw[PB_D] = 1'b1; c0 = cyc;
    wait_cyc(85);
    chk("rep_npulse", pcnt[PB_D], 4);
    chk("rep_gap_first", (pt1.size() >= 2) ? (pt1[1] - pt1[0]) : -1, 32);
    chk("rep_gap_next", (pt1.size() >= 3) ? (pt1[2] - pt1[1]) : -1, 16);
    chk("rep_gap_last", (pt1.size() >= 4) ? (pt1[3] - pt1[2]) : -1, 16);
    push_raw[PB_D] = 1'b0; c0 = cyc;
    wait_cyc(20);
    chk("rep_nrelease", rcnt_obs[PB_D], 1);
    chk("rep_release_latency_in_11_15", 32'((fr[PB_D] - c0 >= 11) && (fr[PB_D] - c0 <= 15)), 1);
    chk("rep_npulse_after_release", pcnt[PB_D], 4);

    // Short low glitch while held
    clear_counts();
    push_raw[PB_U] = 1'b1;
    wait_cyc(20);
    chk("glitch_press", pcnt[PB_U], 1);
    clear_counts();
    push_raw[PB_U] = 1'b0;
    wait_cyc(2);
    push_raw[PB_U] = 1'b1;
    wait_cyc(12);
    chk("glitch_npulse", pcnt[PB_U], 0);
    chk("glitch_nrelease", rcnt_obs[PB_U], 0);
    chk("glitch_level", 32'(push_level[PB_U]), 1);
    push_raw[PB_U] = 1'b0;
    wait_cyc(20);

    // All buttons at once
    clear_counts();
    push_raw = 5'b11111;
    wait_cyc(20);
    chk("simul_all_pulse", 32'(saw_all), 1);
    chk("simul_npulse_m", pcnt[PB_M], 1);
    push_raw = '0;
    wait_cyc(20);

    // Reset while held, button kept down through reset
    push_raw[PB_L] = 1'b1;
    wait_cyc(20);
    chk("rhold_level", 32'(push_level[PB_L]), 1);
    reset = 1'b1;
    #1;
    chk("rhold_level_rst", 32'(push_level), 0);
    chk("rhold_pulse_rst", 32'(push_pulse), 0);
    chk("rhold_release_rst", 32'(push_release), 0);
    wait_cyc(2);
    clear_counts();
    reset = 1'b0;
    wait_cyc(25);
    chk("rhold_npulse", pcnt[PB_L], 1);
    chk("rhold_level_after", 32'(push_level[PB_L]), 1);
    push_raw[PB_L] = 1'b0;
    wait_cyc(20);

    // Random per-button hold durations, including a mid-run reset
    for (int i = 0; i < 5; i++) dur[i] = 0;
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (dur[i] == 0) begin
          push_raw[i] = 1'($urandom_range(0, 1));
          dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 70));
        end
        dur[i]--;
      end
      reset = (n == 1200);
      wait_cyc(1);
    end
    reset = 1'b0;
    push_raw = '0;
    wait_cyc(30);
    chk("final_level", 32'(push_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
